plru_set_array: RTL and testbench

PLRU_SET_ARRAY -- requirements
Module: plru_set_array

---
 rtl/plru_pkg.sv | 19 +
 rtl/plru_tree_logic.sv | 76 +++++++
 rtl/plru_set_array.sv | 143 ++++++++++++++
 tb/tb_plru_set_array.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plru_pkg.sv
// ----------------------------------------------------------------------------
// plru_pkg
// Shared definitions for the tree-PLRU set array.
//   sweep_state_e : states of the flush sweep controller (IDLE / SWEEP)
//   node_count()  : number of tree nodes for an associativity of 2^ways_log2
// ----------------------------------------------------------------------------
package plru_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } sweep_state_e;

   // A binary tree over 2^n leaves has 2^n - 1 internal nodes.
   function automatic int node_count(input int ways_log2);
      return (1 << ways_log2) - 1;
   endfunction

endpackage

// File: rtl/plru_tree_logic.sv
// ----------------------------------------------------------------------------
// plru_tree_logic
// Combinational tree-PLRU logic for a single set.
//   i_tree      : current tree node bits of the set
//   i_valid     : current per-way valid bits of the set
//   i_way       : way being accessed or invalidated
//   i_inv       : 1 = invalidate i_way, 0 = access (mark MRU and valid)
//   o_victim    : lowest invalid way, otherwise the tree victim
//   o_tree_nxt  : tree bits after applying the access/invalidate
//   o_valid_nxt : valid bits after applying the access/invalidate
// ----------------------------------------------------------------------------
module plru_tree_logic
   import plru_pkg::*;
#(
   parameter  int WAYS_LOG2 = 2,
   localparam int WAYS      = 1 << WAYS_LOG2,
   localparam int NODES     = node_count(WAYS_LOG2)
) (
   input  logic [NODES-1:0]     i_tree,
   input  logic [WAYS-1:0]      i_valid,
   input  logic [WAYS_LOG2-1:0] i_way,
   input  logic                 i_inv,
   output logic [WAYS_LOG2-1:0] o_victim,
   output logic [NODES-1:0]     o_tree_nxt,
   output logic [WAYS-1:0]      o_valid_nxt
);

   logic [WAYS_LOG2-1:0] w_tree_way;
   logic [WAYS_LOG2-1:0] w_inv_way;
   logic                 w_any_inv;

   // Tree walk: level i sits at node (2^i - 1) + (way bits already chosen).
   // Bits above i are still zero while level i is evaluated, so the partial
   // way value is exactly the prefix.
   always_comb begin : victim_walk
      logic [WAYS_LOG2-1:0] v_node;
      v_node     = '0;
      w_tree_way = '0;
      for (int i = 0; i < WAYS_LOG2; i++) begin
         v_node        = WAYS_LOG2'((1 << i) - 1) + w_tree_way;
         w_tree_way[i] = i_tree[v_node];
      end
   end

   // Descending scan so the last hit is the lowest-indexed invalid way.
   always_comb begin : lowest_invalid
      w_any_inv = 1'b0;
      w_inv_way = '0;
      for (int k = WAYS - 1; k >= 0; k--) begin
         if (!i_valid[k]) begin
            w_any_inv = 1'b1;
            w_inv_way = WAYS_LOG2'(k);
         end
      end
   end

   assign o_victim = w_any_inv ? w_inv_way : w_tree_way;

   // Access points every path node away from the way (it becomes MRU);
   // invalidate points every path node toward it (it becomes the victim).
   always_comb begin : next_state
      logic [WAYS_LOG2-1:0] v_mask;
      logic [WAYS_LOG2-1:0] v_node;
      v_mask      = '0;
      v_node      = '0;
      o_tree_nxt  = i_tree;
      o_valid_nxt = i_valid;
      for (int i = 0; i < WAYS_LOG2; i++) begin
         v_mask             = WAYS_LOG2'((1 << i) - 1);
         v_node             = v_mask + (i_way & v_mask);
         o_tree_nxt[v_node] = i_inv ? i_way[i] : ~i_way[i];
      end
      o_valid_nxt[i_way] = ~i_inv;
   end

endmodule

// File: rtl/plru_set_array.sv
// ----------------------------------------------------------------------------
// plru_set_array
// Per-set tree-PLRU replacement state with valid bits and a flush sweeper.
//   clk                      : clock, all state updates on the rising edge
//   rst_n                    : asynchronous active-low reset
//   lkp_set / victim_way     : lookup set and its replacement way
//   upd_en/upd_set/upd_way   : access (hit or fill), marks way MRU and valid
//   inv_en/inv_set/inv_way   : invalidate one way, making it the tree victim
//   flush                    : start a sweep clearing every set, one per cycle
//   busy                     : sweep in progress (updates/flush ignored)
// ----------------------------------------------------------------------------
module plru_set_array
   import plru_pkg::*;
#(
   parameter int WAYS_LOG2 = 2,
   parameter int SETS_LOG2 = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [SETS_LOG2-1:0] lkp_set,
   output logic [WAYS_LOG2-1:0] victim_way,
   input  logic                 upd_en,
   input  logic [SETS_LOG2-1:0] upd_set,
   input  logic [WAYS_LOG2-1:0] upd_way,
   input  logic                 inv_en,
   input  logic [SETS_LOG2-1:0] inv_set,
   input  logic [WAYS_LOG2-1:0] inv_way,
   input  logic                 flush,
   output logic                 busy
);

   localparam int WAYS  = 1 << WAYS_LOG2;
   localparam int SETS  = 1 << SETS_LOG2;
   localparam int NODES = node_count(WAYS_LOG2);

   logic [NODES-1:0]     r_tree  [SETS];
   logic [WAYS-1:0]      r_valid [SETS];
   sweep_state_e         r_state;
   logic [SETS_LOG2-1:0] r_cnt;
   logic                 r_busy;

   logic                 w_sweep;
   logic                 w_inv_eff;
   logic                 w_upd_eff;
   logic [NODES-1:0]     w_upd_tree;
   logic [WAYS-1:0]      w_upd_valid;
   logic [NODES-1:0]     w_inv_tree;
   logic [WAYS-1:0]      w_inv_valid;
   logic [NODES-1:0]     w_lkp_unused_tree;
   logic [WAYS-1:0]      w_lkp_unused_valid;
   logic [WAYS_LOG2-1:0] w_upd_unused_victim;
   logic [WAYS_LOG2-1:0] w_inv_unused_victim;

   assign w_sweep   = (r_state == ST_SWEEP);
   assign w_inv_eff = inv_en & ~w_sweep;
   // An invalidate to the same set owns that set this cycle; the access is dropped.
   assign w_upd_eff = upd_en & ~w_sweep & ~(w_inv_eff & (inv_set == upd_set));
   assign busy      = r_busy;

   plru_tree_logic #(.WAYS_LOG2(WAYS_LOG2)) u_lkp (
      .i_tree      (r_tree[lkp_set]),
      .i_valid     (r_valid[lkp_set]),
      .i_way       ('0),
      .i_inv       (1'b0),
      .o_victim    (victim_way),
      .o_tree_nxt  (w_lkp_unused_tree),
      .o_valid_nxt (w_lkp_unused_valid)
   );

   plru_tree_logic #(.WAYS_LOG2(WAYS_LOG2)) u_upd (
      .i_tree      (r_tree[upd_set]),
      .i_valid     (r_valid[upd_set]),
      .i_way       (upd_way),
      .i_inv       (1'b0),
      .o_victim    (w_upd_unused_victim),
      .o_tree_nxt  (w_upd_tree),
      .o_valid_nxt (w_upd_valid)
   );

   plru_tree_logic #(.WAYS_LOG2(WAYS_LOG2)) u_inv (
      .i_tree      (r_tree[inv_set]),
      .i_valid     (r_valid[inv_set]),
      .i_way       (inv_way),
      .i_inv       (1'b1),
      .o_victim    (w_inv_unused_victim),
      .o_tree_nxt  (w_inv_tree),
      .o_valid_nxt (w_inv_valid)
   );

   // Sweep controller: counter wrap from max back to 0 ends the sweep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (flush) begin
                  r_state <= ST_SWEEP;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            ST_SWEEP: begin
               r_cnt <= r_cnt + SETS_LOG2'(1);
               if (r_cnt == '1) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Set storage. w_upd_eff already excludes the same-set case, so the two
   // writes never target the same entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) begin
            r_tree[s]  <= '0;
            r_valid[s] <= '0;
         end
      end else if (w_sweep) begin
         r_tree[r_cnt]  <= '0;
         r_valid[r_cnt] <= '0;
      end else begin
         if (w_upd_eff) begin
            r_tree[upd_set]  <= w_upd_tree;
            r_valid[upd_set] <= w_upd_valid;
         end
         if (w_inv_eff) begin
            r_tree[inv_set]  <= w_inv_tree;
            r_valid[inv_set] <= w_inv_valid;
         end
      end
   end

endmodule

// File: tb/tb_plru_set_array.sv
module tb_plru_set_array;

   logic       clk;
   logic       rst_n;
   logic [2:0] lkp_set;
   logic [1:0] victim_way;
   logic       upd_en;
   logic [2:0] upd_set;
   logic [1:0] upd_way;
   logic       inv_en;
   logic [2:0] inv_set;
   logic [1:0] inv_way;
   logic       flush;
   logic       busy;

   int total = 0;
   int bad   = 0;

   plru_set_array #(.WAYS_LOG2(2), .SETS_LOG2(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .lkp_set    (lkp_set),
      .victim_way (victim_way),
      .upd_en     (upd_en),
      .upd_set    (upd_set),
      .upd_way    (upd_way),
      .inv_en     (inv_en),
      .inv_set    (inv_set),
      .inv_way    (inv_way),
      .flush      (flush),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic access(input logic [2:0] s, input logic [1:0] w);
      upd_en  = 1'b1;
      upd_set = s;
      upd_way = w;
      tick();
      upd_en  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      lkp_set = 3'd5;
      #3;
      total++;
      if (victim_way !== 2'd0) begin
         bad++;
         $display("FAIL reset_victim got=%0d want=0", victim_way);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_busy got=%b want=0", busy);
      end
      tick();
      rst_n = 1'b1;
      for (int s = 0; s < 8; s++) begin
         lkp_set = 3'(s);
         #1;
         total++;
         if (victim_way !== 2'd0) begin
            bad++;
            $display("FAIL reset_set%0d_victim got=%0d want=0", s, victim_way);
         end
      end
   endtask

   task automatic test_fill();
      logic [1:0] exp_fill [4];
      logic [1:0] prev;
      exp_fill = '{2'd1, 2'd2, 2'd3, 2'd0};
      prev     = 2'd0;
      lkp_set  = 3'd2;
      for (int i = 0; i < 4; i++) begin
         upd_en  = 1'b1;
         upd_set = 3'd2;
         upd_way = 2'(i);
         #1;
         total++;
         if (victim_way !== prev) begin
            bad++;
            $display("FAIL fill%0d_no_bypass got=%0d want=%0d", i, victim_way, prev);
         end
         tick();
         upd_en = 1'b0;
         total++;
         if (victim_way !== exp_fill[i]) begin
            bad++;
            $display("FAIL fill%0d_victim got=%0d want=%0d", i, victim_way, exp_fill[i]);
         end
         prev = exp_fill[i];
      end
      access(3'd2, 2'd0);
      total++;
      if (victim_way !== 2'd1) begin
         bad++;
         $display("FAIL reaccess_way0 got=%0d want=1", victim_way);
      end
   endtask

   task automatic test_inv_then_upd();
      lkp_set = 3'd2;
      inv_en  = 1'b1;
      inv_set = 3'd2;
      inv_way = 2'd3;
      tick();
      inv_en = 1'b0;
      total++;
      if (victim_way !== 2'd3) begin
         bad++;
         $display("FAIL inv_way3 got=%0d want=3", victim_way);
      end
      // Tree 1,1,1 after the invalidate; access of way 3 clears nodes 0 and 2.
      access(3'd2, 2'd3);
      total++;
      if (victim_way !== 2'd2) begin
         bad++;
         $display("FAIL upd_way3 got=%0d want=2", victim_way);
      end
   endtask

   task automatic test_same_cycle();
      // Empty set: the dropped access must not validate way 1.
      lkp_set = 3'd4;
      upd_en  = 1'b1; upd_set = 3'd4; upd_way = 2'd1;
      inv_en  = 1'b1; inv_set = 3'd4; inv_way = 2'd1;
      tick();
      upd_en = 1'b0; inv_en = 1'b0;
      total++;
      if (victim_way !== 2'd0) begin
         bad++;
         $display("FAIL same_set_empty got=%0d want=0", victim_way);
      end
      lkp_set = 3'd5;
      access(3'd5, 2'd0);
      access(3'd5, 2'd1);
      total++;
      if (victim_way !== 2'd2) begin
         bad++;
         $display("FAIL set5_two_fills got=%0d want=2", victim_way);
      end
      upd_en  = 1'b1; upd_set = 3'd5; upd_way = 2'd1;
      inv_en  = 1'b1; inv_set = 3'd5; inv_way = 2'd1;
      tick();
      upd_en = 1'b0; inv_en = 1'b0;
      total++;
      if (victim_way !== 2'd1) begin
         bad++;
         $display("FAIL same_set_inv_wins got=%0d want=1", victim_way);
      end
      // Different sets in one cycle: both apply.
      upd_en  = 1'b1; upd_set = 3'd6; upd_way = 2'd0;
      inv_en  = 1'b1; inv_set = 3'd2; inv_way = 2'd1;
      tick();
      upd_en = 1'b0; inv_en = 1'b0;
      lkp_set = 3'd6;
      #1;
      total++;
      if (victim_way !== 2'd1) begin
         bad++;
         $display("FAIL diff_set_upd got=%0d want=1", victim_way);
      end
      lkp_set = 3'd2;
      #1;
      total++;
      if (victim_way !== 2'd1) begin
         bad++;
         $display("FAIL diff_set_inv got=%0d want=1", victim_way);
      end
   endtask

   task automatic test_flush();
      int n;
      lkp_set = 3'd1;
      access(3'd1, 2'd0);
      total++;
      if (victim_way !== 2'd1) begin
         bad++;
         $display("FAIL preflush_set1 got=%0d want=1", victim_way);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 20) begin
         n++;
         if (n == 2) begin
            upd_en = 1'b1; upd_set = 3'd0; upd_way = 2'd0;
            inv_en = 1'b1; inv_set = 3'd7; inv_way = 2'd2;
            flush  = 1'b1;
         end
         if (n == 3) begin
            upd_en = 1'b0; inv_en = 1'b0; flush = 1'b0;
         end
         tick();
      end
      upd_en = 1'b0; inv_en = 1'b0; flush = 1'b0;
      total++;
      if (n !== 8) begin
         bad++;
         $display("FAIL flush_busy_cycles got=%0d want=8", n);
      end
      tick();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL flush_no_restart got=%b want=0", busy);
      end
      for (int s = 0; s < 8; s++) begin
         lkp_set = 3'(s);
         #1;
         total++;
         if (victim_way !== 2'd0) begin
            bad++;
            $display("FAIL postflush_set%0d got=%0d want=0", s, victim_way);
         end
      end
   endtask

   task automatic test_reset_mid_sweep();
      int n;
      lkp_set = 3'd3;
      access(3'd3, 2'd0);
      total++;
      if (victim_way !== 2'd1) begin
         bad++;
         $display("FAIL presweep_set3 got=%0d want=1", victim_way);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      tick();
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL sweep_cycle3_busy got=%b want=1", busy);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL midsweep_reset_busy got=%b want=0", busy);
      end
      total++;
      if (victim_way !== 2'd0) begin
         bad++;
         $display("FAIL midsweep_reset_set3 got=%0d want=0", victim_way);
      end
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (busy !== 1'b0) n++;
      end
      total++;
      if (n !== 0) begin
         bad++;
         $display("FAIL no_resume busy_cycles got=%0d want=0", n);
      end
      for (int s = 0; s < 8; s++) begin
         lkp_set = 3'(s);
         #1;
         total++;
         if (victim_way !== 2'd0) begin
            bad++;
            $display("FAIL postreset_set%0d got=%0d want=0", s, victim_way);
         end
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      lkp_set = 3'd0;
      upd_en  = 1'b0; upd_set = 3'd0; upd_way = 2'd0;
      inv_en  = 1'b0; inv_set = 3'd0; inv_way = 2'd0;
      flush   = 1'b0;
      test_reset();
      test_fill();
      test_inv_then_upd();
      test_same_cycle();
      test_flush();
      test_reset_mid_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
